// File: rtl/dac_pkg.sv
// dac_pkg: shared select codes, FSM state type and mid-scale constant
package dac_pkg;
  localparam logic [1:0] SEL_A = 2'b10;
  localparam logic [1:0] SEL_B = 2'b11;
  localparam logic [1:0] SEL_C = 2'b00;
  localparam logic [1:0] SEL_PWR = 2'b01;
  localparam logic [15:0] MIDSCALE = 16'h8000;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
endpackage

// File: rtl/dac_code_conv.sv
// dac_code_conv: signed setpoint to offset-binary DAC code, clamped to [CLAMP_LO, CLAMP_HI]
module dac_code_conv #(
  parameter logic [15:0] CLAMP_LO = 16'h0000,
  parameter logic [15:0] CLAMP_HI = 16'hFFFF
) (
  input  logic [15:0] i_data,
  output logic [15:0] o_code
);
  logic [15:0] w_off;
  logic [16:0] w_dlo, w_dhi;
  assign w_off = {~i_data[15], i_data[14:0]};
  assign w_dlo = {1'b0, w_off} - {1'b0, CLAMP_LO};
  assign w_dhi = {1'b0, CLAMP_HI} - {1'b0, w_off};
  assign o_code = w_dlo[16] ? CLAMP_LO : w_dhi[16] ? CLAMP_HI : w_off;
endmodule

// File: rtl/dac_update_sched.sv
// dac_update_sched: shadows setpoints, snapshots on tick, sequences A/B/C frames (DAC_PWR_REFRESH_EN adds periodic power-up frame)
module dac_update_sched
  import dac_pkg::*;
#(
  parameter logic [15:0] CLAMP_LO = 16'h0000,
  parameter logic [15:0] CLAMP_HI = 16'hFFFF,
  parameter int BUSY_TIMEOUT = 8
`ifdef DAC_PWR_REFRESH_EN
  , parameter int REFRESH_TICKS = 1000
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        sample_valid,
  input  logic [1:0]  sample_ch,
  input  logic [15:0] sample_data,
  input  logic        dac_done,
  output logic [2:0]  trig,
  output logic [15:0] dac_data_a,
  output logic [15:0] dac_data_b,
  output logic [15:0] dac_data_c,
  output logic        busy,
  output logic [15:0] overrun_cnt,
  output logic        timeout_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  state_t r_st, w_st;
  logic [1:0] r_sel, w_sel;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_trig;
  logic [15:0] r_sh_a, r_sh_b, r_sh_c, r_da, r_db, r_dc, r_ovr, w_code;
  logic r_busy, r_to, w_go, w_to, w_pwr, w_acc;
  assign w_acc = r_st == IDLE && tick;
  dac_code_conv #(.CLAMP_LO(CLAMP_LO), .CLAMP_HI(CLAMP_HI)) u_conv (
    .i_data(sample_data),
    .o_code(w_code)
  );
`ifdef DAC_PWR_REFRESH_EN
  localparam int TW = $clog2(REFRESH_TICKS + 1);
  logic [TW-1:0] r_tcnt;
  logic r_pwr;
  // counts accepted ticks and flags the update that owes a power-up frame
  always_ff @(posedge clk)
    if (reset) begin
      r_tcnt <= '0;
      r_pwr <= 1'b0;
    end else if (w_acc) begin
      r_pwr <= r_tcnt == TW'(REFRESH_TICKS - 1);
      r_tcnt <= r_tcnt == TW'(REFRESH_TICKS - 1) ? '0 : r_tcnt + 1'b1;
    end
  assign w_pwr = r_pwr;
`else
  assign w_pwr = 1'b0;
`endif
  // FSM state register
  always_ff @(posedge clk)
    if (reset) r_st <= IDLE;
    else r_st <= w_st;
  // next state, slot advance, start pulse and timeout detection
  always_comb begin
    w_st = r_st;
    w_sel = r_sel;
    w_go = 1'b0;
    w_to = 1'b0;
    case (r_st)
      IDLE: if (tick) begin
        w_st = ARM;
        w_sel = SEL_A;
      end
      ARM: begin
        w_st = WAIT_BUSY;
        w_go = 1'b1;
      end
      WAIT_BUSY: if (!dac_done) w_st = WAIT_DONE;
      else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
        w_st = IDLE;
        w_to = 1'b1;
      end
      WAIT_DONE: if (dac_done) w_st = NEXT;
      NEXT: begin
        w_sel = r_sel == SEL_A ? SEL_B : r_sel == SEL_B ? SEL_C : SEL_PWR;
        w_st = (r_sel == SEL_PWR || (r_sel == SEL_C && !w_pwr)) ? IDLE : ARM;
      end
      default: w_st = IDLE;
    endcase
  end
  // trigger, shadow/snapshot registers, busy, overrun and timeout flags
  always_ff @(posedge clk)
    if (reset) begin
      r_sel <= SEL_A;
      r_cnt <= '0;
      r_trig <= 3'b100;
      r_busy <= 1'b0;
      r_ovr <= '0;
      r_to <= 1'b0;
      r_sh_a <= MIDSCALE;
      r_sh_b <= MIDSCALE;
      r_sh_c <= MIDSCALE;
      r_da <= MIDSCALE;
      r_db <= MIDSCALE;
      r_dc <= MIDSCALE;
    end else begin
      r_sel <= w_sel;
      r_cnt <= r_st == WAIT_BUSY ? r_cnt + 1'b1 : '0;
      r_trig <= w_go ? {r_sel, 1'b1} : {r_trig[2:1], 1'b0};
      r_busy <= w_st != IDLE;
      if (w_to) r_to <= 1'b1;
      if (tick && r_st != IDLE && r_ovr != 16'hFFFF) r_ovr <= r_ovr + 1'b1;
      if (w_acc) begin
        r_da <= r_sh_a;
        r_db <= r_sh_b;
        r_dc <= r_sh_c;
      end
      if (sample_valid && sample_ch == 2'd0) r_sh_a <= w_code;
      if (sample_valid && sample_ch == 2'd1) r_sh_b <= w_code;
      if (sample_valid && sample_ch == 2'd2) r_sh_c <= w_code;
    end
  assign trig = r_trig;
  assign dac_data_a = r_da;
  assign dac_data_b = r_db;
  assign dac_data_c = r_dc;
  assign busy = r_busy;
  assign overrun_cnt = r_ovr;
  assign timeout_err = r_to;
endmodule

// File: tb/tb_dac_update_sched.sv
// tb_dac_update_sched: scoreboard bench with a simple downstream frame model
`timescale 1ns/1ps
module tb_dac_update_sched;
  import dac_pkg::*;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, sample_valid = 1'b0, dac_done, hold = 1'b0;
  logic [1:0] sample_ch = 2'd0;
  logic [15:0] sample_data = 16'h0000;
  logic [2:0] trig, c_trig;
  logic [15:0] d_a, d_b, d_c, ovr, c_a, c_b, c_c, c_ovr;
  logic busy, to_err, c_busy, c_to;
  int total = 0, bad = 0, n_acc = 0;
  typedef struct packed {logic [1:0] sel; logic [15:0] a, b, c;} exp_t;
  exp_t q[$];

  always #40 clk = ~clk;

  dac_update_sched
`ifdef DAC_PWR_REFRESH_EN
    #(.REFRESH_TICKS(3))
`endif
  u_dut (
    .clk(clk), .reset(reset), .tick(tick), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .dac_done(dac_done), .trig(trig), .dac_data_a(d_a), .dac_data_b(d_b),
    .dac_data_c(d_c), .busy(busy), .overrun_cnt(ovr), .timeout_err(to_err)
  );

  dac_update_sched #(
    .CLAMP_HI(16'hF000)
`ifdef DAC_PWR_REFRESH_EN
    , .REFRESH_TICKS(3)
`endif
  ) u_clp (
    .clk(clk), .reset(reset), .tick(tick), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .dac_done(dac_done), .trig(c_trig), .dac_data_a(c_a), .dac_data_b(c_b),
    .dac_data_c(c_c), .busy(c_busy), .overrun_cnt(c_ovr), .timeout_err(c_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input bit full);
    n_acc++;
    q.push_back({SEL_A, a, b, c});
    if (full) begin
      q.push_back({SEL_B, a, b, c});
      q.push_back({SEL_C, a, b, c});
`ifdef DAC_PWR_REFRESH_EN
      if (n_acc % 3 == 0) q.push_back({SEL_PWR, a, b, c});
`endif
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_ch = ch;
    sample_data = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_tick;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_frames_left"}, q.size(), 32'd0);
  endtask

  // monitor: every start pulse must match the next expected frame
  always @(negedge clk)
    if (!reset && trig[0]) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got sel %b expected no frame", trig[2:1]);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_sel", 32'(trig[2:1]), 32'(e.sel));
        chk("frame_a", 32'(d_a), 32'(e.a));
        chk("frame_b", 32'(d_b), 32'(e.b));
        chk("frame_c", 32'(d_c), 32'(e.c));
        chk("frame_busy", 32'(busy), 32'd1);
        chk("frame_after_done", 32'(dac_done), 32'd1);
      end
    end

  // downstream stage model: done falls a cycle after the pulse, rises 5 cycles later
  initial begin
    logic [1:0] s;
    dac_done = 1'b1;
    forever begin
      @(negedge clk);
      if (trig[0] && !hold && !reset) begin
        s = trig[2:1];
        @(negedge clk);
        chk("sel_hold", 32'(trig[2:1]), 32'(s));
        dac_done = 1'b0;
        repeat (5) @(negedge clk);
        dac_done = 1'b1;
      end
    end
  end

  initial begin
    #(80 * 20000);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_trig", 32'(trig), 32'h4);
    chk("rst_a", 32'(d_a), 32'h8000);
    chk("rst_b", 32'(d_b), 32'h8000);
    chk("rst_c", 32'(d_c), 32'h8000);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_to", 32'(to_err), 32'd0);
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h7FFF);
    wr(2'd2, 16'h8000);
    pulse_tick();
    push(16'h8000, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle("basic");
    wr(2'd0, 16'h7FFF);
    pulse_tick();
    push(16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle("clamp");
    chk("clamp_a", 32'(c_a), 32'hF000);
    chk("clamp_b", 32'(c_b), 32'hF000);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h1234);
    @(posedge clk); #1;
    tick = 1'b1;
    sample_valid = 1'b1;
    sample_ch = 2'd0;
    sample_data = 16'h1000;
    @(posedge clk); #1;
    tick = 1'b0;
    sample_valid = 1'b0;
    push(16'h8000, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle("same_cycle");
    pulse_tick();
    push(16'h9000, 16'hFFFF, 16'h0000, 1'b1);
    wait_idle("following");
    chk("ovr_before", 32'(ovr), 32'd0);
    pulse_tick();
    push(16'h9000, 16'hFFFF, 16'h0000, 1'b1);
    repeat (20) @(posedge clk);
    pulse_tick();
    wait_idle("overrun");
    chk("ovr_after", 32'(ovr), 32'd1);
    hold = 1'b1;
    pulse_tick();
    push(16'h9000, 16'hFFFF, 16'h0000, 1'b0);
    n = 0;
    while (!trig[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    m = 0;
    while (!to_err && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("timeout_lat", m, 32'd8);
    chk("timeout_err", 32'(to_err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    chk("timeout_frames_left", q.size(), 32'd0);
    chk("timeout_sticky", 32'(to_err), 32'd1);
    hold = 1'b0;
    pulse_tick();
    push(16'h9000, 16'hFFFF, 16'h0000, 1'b1);
    n = 0;
    while (!trig[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    n_acc = 0;
    @(negedge clk);
    chk("midrst_trig", 32'(trig), 32'h4);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_a", 32'(d_a), 32'h8000);
    chk("midrst_to", 32'(to_err), 32'd0);
    chk("midrst_ovr", 32'(ovr), 32'd0);
    repeat (30) @(negedge clk);
    chk("midrst_quiet", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
